// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift right / shift left / load) with word-assembly counter; optional parity via SHREG_PARITY_EN.
// Latency: q, bit_cnt, word_valid (and parity_out) register one cycle after the enabling edge; rst clears asynchronously.
// Backpressure: en=0 freezes q and bit_cnt and drops word_valid; there is no other stall path.
module shift_reg_univ #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    bit_cnt,
    output logic             word_valid
`ifdef SHREG_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_RIGHT = 2'b01;
    localparam logic [1:0]    MODE_LEFT  = 2'b10;
    localparam logic [1:0]    MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wv_q, wv_d;
    logic             shift;

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        wv_d  = 1'b0;
        shift = 1'b0;
        if (en) begin
            case (mode)
                MODE_RIGHT: begin
                    q_d   = {sin_r, q_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                MODE_LEFT: begin
                    q_d   = {q_q[WIDTH-2:0], sin_l};
                    shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = pin;
                    cnt_d = '0;
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
        // Direction is irrelevant to word assembly: any shift counts one bit.
        if (shift) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                wv_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            cnt_q <= '0;
            wv_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
            wv_q  <= wv_d;
        end
    end

`ifdef SHREG_PARITY_EN
    logic par_q, par_d;

    // Parity is captured from the completed word on the same edge that raises word_valid.
    always_comb begin
        par_d = par_q;
        if (wv_d) begin
            par_d = ^q_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity_out = par_q;
`endif

    assign q          = q_q;
    assign sout_r     = q_q[0];
    assign sout_l     = q_q[WIDTH-1];
    assign bit_cnt    = cnt_q;
    assign word_valid = wv_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ at WIDTH=4; parity checks are enabled when SHREG_PARITY_EN is defined.
module tb_shift_reg_univ;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH);

    logic             clk    = 1'b0;
    logic             clk_en = 1'b1;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    bit_cnt;
    logic             word_valid;
`ifdef SHREG_PARITY_EN
    logic             parity_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 if (clk_en) clk = ~clk;

    shift_reg_univ #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pin        (pin),
        .q          (q),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .bit_cnt    (bit_cnt),
        .word_valid (word_valid)
`ifdef SHREG_PARITY_EN
        ,
        .parity_out (parity_out)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input int exp_q, input int exp_cnt, input int exp_wv);
        logic [31:0] eq;
        eq = exp_q;
        chk({tag, ".q"},      int'(q),          exp_q);
        chk({tag, ".cnt"},    int'(bit_cnt),    exp_cnt);
        chk({tag, ".wv"},     int'(word_valid), exp_wv);
        chk({tag, ".sout_r"}, int'(sout_r),     int'(eq[0]));
        chk({tag, ".sout_l"}, int'(sout_l),     int'(eq[WIDTH-1]));
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                         input logic [WIDTH-1:0] p);
        en    = e;
        mode  = m;
        sin_r = sr;
        sin_l = sl;
        pin   = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shr(input logic b);
        drive(1'b1, 2'b01, b, 1'b0, '0);
        tick();
    endtask

    task automatic load(input logic [WIDTH-1:0] p);
        drive(1'b1, 2'b11, 1'b0, 1'b0, p);
        tick();
    endtask

    initial begin
        logic [7:0] pat;
        logic [3:0] w1;

        rst = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0, '0);
        #12;
        chk_state("reset", 'b0000, 0, 0);
`ifdef SHREG_PARITY_EN
        chk("reset.par", int'(parity_out), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Serial right-shift assembly of 1,0,1,1.
        w1 = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            shr(w1[3-i]);
            if (i < 3) chk("r4.wv_early", int'(word_valid), 0);
        end
        chk_state("r4", 'b1101, 0, 1);
`ifdef SHREG_PARITY_EN
        chk("r4.par", int'(parity_out), 1);
`endif
        drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
        tick();
        chk_state("hold", 'b1101, 0, 0);

        // Parallel load then shift left.
        load(4'b1001);
        chk_state("load", 'b1001, 0, 0);
`ifdef SHREG_PARITY_EN
        chk("load.par_held", int'(parity_out), 1);
`endif
        drive(1'b1, 2'b10, 1'b0, 1'b0, '0);
        tick();
        chk_state("shl", 'b0010, 1, 0);

        // Enable gap in the middle of a word.
        load(4'b0000);
        shr(1'b1);
        shr(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b01, 1'b0, 1'b0, '0);
            tick();
            chk_state("en_off", 'b1100, 2, 0);
        end
        shr(1'b0);
        chk_state("gap3", 'b0110, 3, 0);
        shr(1'b1);
        chk_state("gap4", 'b1011, 0, 1);

        // Back-to-back words.
        load(4'b0000);
        pat = 8'b1100_1010;
        for (int i = 0; i < 8; i++) begin
            shr(pat[7-i]);
            chk("b2b.wv", int'(word_valid), (i == 3 || i == 7) ? 1 : 0);
            if (i == 3) begin
                chk("b2b.q1", int'(q), 'b0011);
`ifdef SHREG_PARITY_EN
                chk("b2b.par1", int'(parity_out), 0);
`endif
            end
        end
        chk_state("b2b", 'b0101, 0, 1);
`ifdef SHREG_PARITY_EN
        chk("b2b.par2", int'(parity_out), 0);
`endif

        // Load mid-word restarts the count.
        load(4'b0000);
        for (int i = 0; i < 3; i++) shr(1'b1);
        chk_state("pre_ld", 'b1110, 3, 0);
        load(4'b0110);
        chk_state("mid_ld", 'b0110, 0, 0);
        for (int i = 0; i < 4; i++) begin
            shr(1'b0);
            if (i < 3) chk("post_ld.wv", int'(word_valid), 0);
        end
        chk_state("post_ld", 'b0000, 0, 1);

        // Asynchronous reset with the clock stopped, while word_valid is high.
        for (int i = 0; i < 4; i++) shr(1'b1);
        chk_state("pre_rst", 'b1111, 0, 1);
        clk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_state("async_rst", 'b0000, 0, 0);
        #2 rst = 1'b0;
        drive(1'b0, 2'b01, 1'b1, 1'b0, '0);
        clk_en = 1'b1;
        tick();
        chk_state("post_rst_en0", 'b0000, 0, 0);

        // Reset mid-word discards the partial word.
        shr(1'b1);
        shr(1'b1);
        chk("mid.cnt", int'(bit_cnt), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_state("mid_rst", 'b0000, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shr(1'b0);
            if (i < 3) chk("new_word.wv", int'(word_valid), 0);
        end
        chk_state("new_word", 'b0000, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
